// File: rtl/mfda_ctrl_pkg.sv
// Shared definitions for the microfluidic tree controllers.
// Holds the controller state set, the phase-length type and a sizing helper.
package mfda_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_FILL,
    ST_MIX,
    ST_XFER,
    ST_FLUSH,
    ST_DONE
  } ctrl_state_e;

  typedef int unsigned phase_len_t;

  function automatic phase_len_t max_len(input phase_len_t a, input phase_len_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mix_tree_sequencer_if.sv
// Run-control, pump handshake and valve/actuator bundle of the mix tree sequencer.
// The master side is the sequencer; the slave side is the host/driver bank.
interface mix_tree_sequencer_if #(
  parameter int NUM_STAGES = 7
) ();

  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  start;
  logic                  abort;
  logic                  pump_ack;
  logic                  pump_req;
  logic [NUM_STAGES-1:0] inlet_vlv;
  logic [NUM_STAGES-1:0] mix_en;
  logic [NUM_STAGES-1:0] outlet_vlv;
  logic [STAGE_W-1:0]    stage_idx;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    input  start, abort, pump_ack,
    output pump_req, inlet_vlv, mix_en, outlet_vlv, stage_idx, busy, done, aborted
  );

  modport slave (
    output start, abort, pump_ack,
    input  pump_req, inlet_vlv, mix_en, outlet_vlv, stage_idx, busy, done, aborted
  );

endinterface

// File: rtl/mix_tree_sequencer_phase_timer.sv
// Loadable down-counter timing one phase; tc marks the last cycle of the phase.
// Load takes priority over hold, and the count never wraps below zero.
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!hold && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == WIDTH'(1));

endmodule

// File: rtl/mix_tree_sequencer.sv
// Sequences one sample batch through the split-mixer tree: prime, per-row fill/mix/transfer, flush.
// All outputs are registered from the next state, so nothing on the bus depends combinationally on inputs.
module mix_tree_sequencer
  import mfda_ctrl_pkg::*;
#(
  parameter int                    NUM_STAGES = 7,
  parameter phase_len_t            FILL_CYC   = 16,
  parameter phase_len_t            MIX_CYC    = 64,
  parameter phase_len_t            XFER_CYC   = 8,
  parameter phase_len_t            FLUSH_CYC  = 32,
  parameter logic [NUM_STAGES-1:0] MIX_MASK   = 7'b1011111
) (
  input  logic                 clk,
  input  logic                 rst,
  mix_tree_sequencer_if.master bus
);

  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CNT_W   = $clog2(max_len(max_len(FILL_CYC, MIX_CYC),
                                          max_len(XFER_CYC, FLUSH_CYC)) + 1);

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [STAGE_W-1:0] stage_t;

  localparam stage_t LAST_STAGE = stage_t'(NUM_STAGES - 1);

  ctrl_state_e           state_q, state_d;
  stage_t                stage_q, stage_d;
  logic                  abort_flag_q, abort_flag_d;
  logic                  tmr_load, tmr_tc, in_phase, stall;
  cnt_t                  tmr_val;
  logic [NUM_STAGES-1:0] stage_bit;
  logic [NUM_STAGES-1:0] inlet_q, inlet_d, mix_q, mix_d, outlet_q, outlet_d;
  logic                  pump_req_q, pump_req_d, busy_q, busy_d;
  logic                  done_q, done_d, aborted_q, aborted_d;

  phase_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .hold     (stall),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign in_phase = (state_q == ST_FILL) || (state_q == ST_MIX) || (state_q == ST_XFER);
  assign stall    = in_phase && !bus.pump_ack;

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    abort_flag_d = abort_flag_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d      = ST_PRIME;
          stage_d      = '0;
          abort_flag_d = 1'b0;
        end
      end
      ST_PRIME: begin
        if (bus.pump_ack) begin
          state_d  = ST_FILL;
          stage_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = cnt_t'(FILL_CYC);
        end
      end
      ST_FILL: begin
        if (tmr_tc && bus.pump_ack) begin
          tmr_load = 1'b1;
          if (MIX_MASK[stage_q]) begin
            state_d = ST_MIX;
            tmr_val = cnt_t'(MIX_CYC);
          end else begin
            state_d = ST_XFER;
            tmr_val = cnt_t'(XFER_CYC);
          end
        end
      end
      ST_MIX: begin
        if (tmr_tc && bus.pump_ack) begin
          state_d  = ST_XFER;
          tmr_load = 1'b1;
          tmr_val  = cnt_t'(XFER_CYC);
        end
      end
      ST_XFER: begin
        if (tmr_tc && bus.pump_ack) begin
          tmr_load = 1'b1;
          if (stage_q == LAST_STAGE) begin
            state_d = ST_FLUSH;
            tmr_val = cnt_t'(FLUSH_CYC);
          end else begin
            state_d = ST_FILL;
            stage_d = stage_q + stage_t'(1);
            tmr_val = cnt_t'(FILL_CYC);
          end
        end
      end
      ST_FLUSH: begin
        if (tmr_tc) begin
          state_d = abort_flag_q ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any phase exit decided above, including a coinciding final count.
    if (bus.abort && ((state_q == ST_PRIME) || in_phase)) begin
      state_d      = ST_FLUSH;
      abort_flag_d = 1'b1;
      tmr_load     = 1'b1;
      tmr_val      = cnt_t'(FLUSH_CYC);
    end
  end

  always_comb begin
    stage_bit          = '0;
    stage_bit[stage_d] = 1'b1;
    pump_req_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    aborted_d  = (state_q == ST_FLUSH) && (state_d == ST_IDLE);
    // A phase entered or held while pressure is missing shows all valves closed.
    inlet_d    = ((state_d == ST_FILL) && bus.pump_ack) ? stage_bit : '0;
    mix_d      = ((state_d == ST_MIX) && bus.pump_ack) ? stage_bit : '0;
    if (state_d == ST_FLUSH) begin
      outlet_d = '1;
    end else begin
      outlet_d = ((state_d == ST_XFER) && bus.pump_ack) ? stage_bit : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      abort_flag_q <= 1'b0;
      inlet_q      <= '0;
      mix_q        <= '0;
      outlet_q     <= '0;
      pump_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      abort_flag_q <= abort_flag_d;
      inlet_q      <= inlet_d;
      mix_q        <= mix_d;
      outlet_q     <= outlet_d;
      pump_req_q   <= pump_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign bus.pump_req   = pump_req_q;
  assign bus.inlet_vlv  = inlet_q;
  assign bus.mix_en     = mix_q;
  assign bus.outlet_vlv = outlet_q;
  assign bus.stage_idx  = stage_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Self-checking bench for mix_tree_sequencer with a small tree (2 rows, short phases).
// The reference model expands each run into a per-cycle queue of phase tokens.
module tb_mix_tree_sequencer;

  localparam int         NS       = 2;
  localparam int         T_FILL   = 2;
  localparam int         T_MIX    = 3;
  localparam int         T_XFER   = 1;
  localparam int         T_FLUSH  = 2;
  localparam logic [1:0] T_MASK   = 2'b01;
  localparam int         VW       = 4 + 3 * NS;

  localparam int P_PRIME  = 1;
  localparam int P_FILL   = 2;
  localparam int P_MIX    = 3;
  localparam int P_XFER   = 4;
  localparam int P_FLUSH  = 5;
  localparam int P_DONE   = 6;
  localparam int P_ABIDLE = 7;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int   q_ph[$];
  int   q_st[$];
  bit   gated;

  mix_tree_sequencer_if #(.NUM_STAGES(NS)) bus_if ();

  mix_tree_sequencer #(
    .NUM_STAGES (NS),
    .FILL_CYC   (T_FILL),
    .MIX_CYC    (T_MIX),
    .XFER_CYC   (T_XFER),
    .FLUSH_CYC  (T_FLUSH),
    .MIX_MASK   (T_MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void push_tok(input int ph, input int st, input int n);
    for (int i = 0; i < n; i++) begin
      q_ph.push_back(ph);
      q_st.push_back(st);
    end
  endfunction

  function automatic void model_reset();
    q_ph.delete();
    q_st.delete();
    gated = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_edge();
    int h;
    h = (q_ph.size() == 0) ? 0 : q_ph[0];
    gated = 1'b0;
    if (h == 0 || h == P_ABIDLE) begin
      if (h == P_ABIDLE) begin
        void'(q_ph.pop_front());
        void'(q_st.pop_front());
      end
      if (bus_if.start) begin
        push_tok(P_PRIME, 0, 1);
        for (int s = 0; s < NS; s++) begin
          push_tok(P_FILL, s, T_FILL);
          if (T_MASK[s]) push_tok(P_MIX, s, T_MIX);
          push_tok(P_XFER, s, T_XFER);
        end
        push_tok(P_FLUSH, 0, T_FLUSH);
        push_tok(P_DONE, 0, 1);
      end
    end else if (bus_if.abort && (h inside {P_PRIME, P_FILL, P_MIX, P_XFER})) begin
      model_reset();
      push_tok(P_FLUSH, 0, T_FLUSH);
      push_tok(P_ABIDLE, 0, 1);
    end else if ((h inside {P_PRIME, P_FILL, P_MIX, P_XFER}) && !bus_if.pump_ack) begin
      gated = (h != P_PRIME);
    end else begin
      void'(q_ph.pop_front());
      void'(q_st.pop_front());
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int h;
    logic [NS-1:0] oh, inl, mx, outl;
    h  = (q_ph.size() == 0) ? 0 : q_ph[0];
    oh = '0;
    if (h != 0) oh[q_st[0]] = 1'b1;
    inl  = (h == P_FILL && !gated) ? oh : '0;
    mx   = (h == P_MIX && !gated) ? oh : '0;
    outl = (h == P_FLUSH) ? '1 : ((h == P_XFER && !gated) ? oh : '0);
    return {(h >= P_PRIME && h <= P_FLUSH), (h >= P_PRIME && h <= P_DONE),
            (h == P_DONE), (h == P_ABIDLE), inl, mx, outl};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus_if.pump_req, bus_if.busy, bus_if.done, bus_if.aborted,
            bus_if.inlet_vlv, bus_if.mix_en, bus_if.outlet_vlv};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.pump_ack = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    model_reset();
    checks++;
    if (act_vec() !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", act_vec(), {VW{1'b0}});
    end
    checks++;
    if (bus_if.stage_idx !== '0) begin
      errors++; $display("[TB] FAIL reset_stage: got %0d expected 0", bus_if.stage_idx);
    end
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // One run with optional pump dropout (edges ack_lo..ack_hi) and abort edge; returns pulse cycles.
  task automatic run_case(input string name, input int ncyc, input int ack_lo, input int ack_hi,
                          input int abort_at, output int done_cyc, output int abort_cyc);
    done_cyc = -1; abort_cyc = -1;
    bus_if.start = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      bus_if.pump_ack = !((cyc - 1) >= ack_lo && (cyc - 1) <= ack_hi);
      bus_if.abort    = ((cyc - 1) == abort_at);
      tick();
      bus_if.start = 1'b0;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act_vec(), exp_vec());
      end
      if (bus_if.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (bus_if.aborted === 1'b1 && abort_cyc < 0) abort_cyc = cyc;
    end
    bus_if.abort = 1'b0; bus_if.pump_ack = 1'b1;
  endtask

  task automatic test_nominal();
    int d, a;
    run_case("nominal", 16, -1, -1, -1, d, a);
    checks++;
    if (d != 13) begin errors++; $display("[TB] FAIL nominal_done_cycle: got %0d expected 13", d); end
    checks++;
    if (a != -1) begin errors++; $display("[TB] FAIL nominal_no_abort: got %0d expected -1", a); end
  endtask

  task automatic test_stall();
    int d, a;
    run_case("stall", 20, 5, 8, -1, d, a);
    checks++;
    if (d != 17) begin errors++; $display("[TB] FAIL stall_done_cycle: got %0d expected 17", d); end
  endtask

  task automatic test_abort(input int at, input int exp_ab);
    int d, a;
    run_case("abort", 16, -1, -1, at, d, a);
    checks++;
    if (a != exp_ab) begin
      errors++; $display("[TB] FAIL abort_pulse_cycle: got %0d expected %0d", a, exp_ab);
    end
    checks++;
    if (d != -1) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected -1", d); end
  endtask

  task automatic test_midrun_reset();
    bus_if.start = 1'b1; bus_if.pump_ack = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      bus_if.start = 1'b0;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL pre_reset cycle %0d: got %b expected %b", cyc, act_vec(), exp_vec());
      end
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act_vec() !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset: got %b expected %b", act_vec(), {VW{1'b0}});
    end
    #1 rst = 1'b0;
    test_nominal();
  endtask

  task automatic test_back_to_back();
    int d1, r2;
    logic prev_busy;
    d1 = -1; r2 = -1; prev_busy = 1'b0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      bus_if.start = ((cyc - 1) < 20);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", cyc, act_vec(), exp_vec());
      end
      if (bus_if.done === 1'b1 && d1 < 0) d1 = cyc;
      if (d1 > 0 && cyc > d1 && bus_if.busy === 1'b1 && !prev_busy && r2 < 0) r2 = cyc;
      prev_busy = bus_if.busy;
    end
    bus_if.start = 1'b0;
    checks++;
    if (d1 != 13) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d expected 13", d1); end
    checks++;
    if (r2 != 15) begin errors++; $display("[TB] FAIL b2b_restart_cycle: got %0d expected 15", r2); end
    for (int cyc = 0; cyc < 16; cyc++) tick();
  endtask

  task automatic test_random();
    int h;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus_if.start    = ($urandom_range(0, 3) == 0);
      bus_if.abort    = ($urandom_range(0, 29) == 0);
      bus_if.pump_ack = ($urandom_range(0, 4) != 0);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL random cycle %0d: got %b expected %b", cyc, act_vec(), exp_vec());
      end
      h = (q_ph.size() == 0) ? 0 : q_ph[0];
      if (h inside {P_FILL, P_MIX, P_XFER}) begin
        checks++;
        if (int'(bus_if.stage_idx) != q_st[0]) begin
          errors++; $display("[TB] FAIL random_stage cycle %0d: got %0d expected %0d", cyc, bus_if.stage_idx, q_st[0]);
        end
      end
    end
    bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.pump_ack = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_nominal();
    test_stall();
    test_abort(5, 8);
    test_abort(10, 13);
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
